// File: rtl/shake_squeeze_out.sv
// Serializes 1088-bit SHAKE256 rate blocks into 64-bit lanes over valid/ready,
// requesting further squeeze permutations until the job's lane count is met.
module shake_squeeze_out #(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned LANES  = 17
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      squeezed,
   input  logic [LANE_W*LANES-1:0]   hash,
   input  logic                      start,
   input  logic [15:0]               out_len,
   input  logic                      out_ready,
   output logic [LANE_W-1:0]         out_data,
   output logic                      out_valid,
   output logic                      out_last,
   output logic                      more,
   output logic                      busy,
   output logic                      overrun
);

   localparam int unsigned BUF_W    = LANE_W * LANES;
   localparam logic [4:0]  LAST_IDX = 5'(LANES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_BLK, STREAM, REQ} state_t;

   state_t             state, state_nxt;
   logic [BUF_W-1:0]   blk_buf;
   logic [15:0]        remaining;
   logic [4:0]         idx;
   logic               avail;
   logic               sq_q;
   logic               sq_edge;
   logic [LANE_W-1:0]  lane_sel;

   assign sq_edge = squeezed & ~sq_q;

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start && out_len != 16'd0) state_nxt = WAIT_BLK;
         WAIT_BLK: if (avail) state_nxt = STREAM;
         STREAM: begin
            if (out_ready) begin
               if (remaining == 16'd1)   state_nxt = IDLE;
               else if (idx == LAST_IDX) state_nxt = REQ;
            end
         end
         REQ:      state_nxt = WAIT_BLK;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         blk_buf   <= '0;
         remaining <= '0;
         idx       <= '0;
         avail     <= 1'b0;
         sq_q      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sq_q <= squeezed;
         case (state)
            IDLE: begin
               if (start && out_len != 16'd0) begin
                  remaining <= out_len;
                  overrun   <= 1'b0;
               end
            end
            WAIT_BLK: begin
               if (avail) begin
                  avail <= 1'b0;
                  idx   <= '0;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  remaining <= remaining - 16'd1;
                  idx       <= idx + 5'd1;
               end
            end
            default: ;
         endcase
         // A fresh capture is placed after the consume so the newest block wins avail.
         if (sq_edge) begin
            if (state == STREAM) begin
               overrun <= 1'b1;
            end else begin
               blk_buf <= hash;
               avail   <= 1'b1;
            end
         end
      end
   end

   // Lane 0 is the most significant 64 bits of the captured block.
   always_comb begin
      lane_sel = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (idx == 5'(k)) lane_sel = blk_buf[BUF_W-1-k*LANE_W -: LANE_W];
      end
   end

   always_comb begin
      out_valid = (state == STREAM);
      busy      = (state != IDLE);
      more      = (state == REQ);
      out_last  = out_valid && (remaining == 16'd1);
      out_data  = out_valid ? lane_sel : '0;
   end

endmodule

// File: doc/shake_squeeze_out.md
# shake_squeeze_out

Output serializer that sits directly downstream of the SHAKE256 core. It captures each 1088-bit rate block the core presents on its `squeezed` pulse. It streams the captured block out as 64-bit lanes over a valid/ready handshake until a requested number of lanes has been delivered. When a block is exhausted and more lanes are owed, it pulses a request for another squeeze permutation.

## Interface
- `LANE_W`, 64: output lane width in bits; fixed at 64 for SHAKE256.
- `LANES`, 17: lanes per rate block (1088 / 64).
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `squeezed`  in  1: core's registered done flag; only its rising edge is significant.
- `hash`  in  1088: core rate output; valid in the cycle of the `squeezed` rising edge.
- `start`  in  1: begin a new output job; sampled only in IDLE.
- `out_len`  in  16: total lanes to deliver; sampled with `start`.
- `out_ready`  in  1: downstream accepts the current lane.
- `out_data`  out  64: current lane.
- `out_valid`  out  1: `out_data` is valid.
- `out_last`  out  1: current lane is the final lane of the job.
- `more`  out  1: one-cycle pulse requesting the next squeeze permutation.
- `busy`  out  1: high in any state other than IDLE.
- `overrun`  out  1: sticky; a block arrived while streaming and was dropped.

## Operation
- Edge detect:
  - `sq_q` is a register of `squeezed`, reset 0.
  - `edge = squeezed & ~sq_q`.
- Block capture, when `edge` is high:
  - In any state except STREAM: `buf <= hash` and `avail <= 1`.
  - In STREAM: `buf` is unchanged and `overrun <= 1`.
- Lane order is MSB-first. Lane k = `buf[1087-64k -: 64]`, so lane 0 = `buf[1087:1024]` and lane 16 = `buf[63:0]`.
- Counters:
  - `remaining` is 16 bits and counts lanes still owed.
  - `idx` is 5 bits and ranges 0..16.
- FSM states: IDLE, WAIT_BLK, STREAM, REQ.
- IDLE:
  - On `start` with `out_len != 0`: `remaining <= out_len`, `overrun <= 0`, go to WAIT_BLK.
  - `start` with `out_len == 0` is ignored and the state stays IDLE.
- WAIT_BLK:
  - If `avail`: `avail <= 0`, `idx <= 0`, go to STREAM.
  - Otherwise hold.
- STREAM:
  - `out_valid = 1`, `out_data` = lane `idx`, `out_last = (remaining == 1)`.
  - On `out_valid & out_ready`: `remaining <= remaining - 1`, `idx <= idx + 1`.
  - If `remaining == 1` at that handshake, go to IDLE.
  - Else if `idx == 16`, go to REQ.
  - Else stay in STREAM.
- REQ: `more = 1` for exactly this one cycle, then go to WAIT_BLK.
- `start` outside IDLE is ignored; `out_len` is not re-sampled.
- A block left in `buf` with `avail = 1` when a job ends stays available. The next job consumes it without a new squeeze; this is intended when the core squeezes ahead.
- Reset (`reset == 0` at a rising edge):
  - Registers: state IDLE; `buf`, `remaining`, `idx`, `avail`, `sq_q` all 0.
  - Outputs: `overrun`, `out_valid`, `out_last`, `more`, `busy` all 0; `out_data` 0.
  - Reset mid-stream aborts the job with no further lanes; it takes priority over every other event.

## Timing
- `out_valid`, `out_last`, `more`, `busy` and `out_data` are decoded from registers only; no input-to-output combinational path.
- From `start` in cycle t:
  - `busy` goes high at t+1.
  - If `avail` is already set, `out_valid` goes high at t+2.
- From a `squeezed` edge in cycle t while in WAIT_BLK: `avail` = 1 at t+1, `out_valid` = 1 at t+2.
- Streaming rate: one lane per cycle while `out_ready` is held high.
- Backpressure: while `out_valid & ~out_ready`, `out_data` and `out_last` hold stable.
- At a block boundary, handshake of lane 16 in cycle t:
  - `more` is high at t+1.
  - The state is WAIT_BLK at t+2.
- Last handshake in cycle t: `out_valid` = 0 and `busy` = 0 at t+1.
- A `squeezed` level held high for several cycles produces exactly one capture.

## Test plan
- Single-block job: preload hash with lane k = 64'h0101010101010101·(k+1), `start` with `out_len = 5`, `out_ready` = 1 → lanes 1..5 on consecutive cycles, `out_last` only on the 5th, `more` never asserted, `busy` low the cycle after the last handshake.
- Multi-block job: `out_len = 20` → 17 lanes, then a one-cycle `more`, then WAIT_BLK. Pulse `squeezed` with new hash → 3 lanes from the new block's lanes 0..2, `out_last` on the 20th lane.
- Backpressure: `out_len = 3`, `out_ready` toggled 1,0,0,1,1 → `out_data` stable during the stall, exactly 3 handshakes, no duplicated or skipped lane.
- Overrun and edge filtering:
  - A `squeezed` pulse during STREAM → `buf` unchanged, `overrun` = 1 until the next accepted `start`.
  - `squeezed` held high for 4 cycles in WAIT_BLK → a single capture.
- Start handling: `start` with `out_len = 0` → stays IDLE, `busy` = 0. `start` during STREAM → ignored, lane count unchanged.
- Reset mid-stream after 7 of 17 lanes → next cycle all outputs 0, state IDLE. A new `start` then waits for a fresh `squeezed` edge (`avail` cleared).
